// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO feeding an 8N1 UART transmitter (LSB first, idle high).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trigger_in,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] c_depth     = CW'(DEPTH);
    localparam logic [15:0]   c_baud_last = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                state_q,    state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q,   wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]         count_q,    count_d;
    logic [7:0]            shift_q,    shift_d;
    logic [2:0]            bit_cnt_q,  bit_cnt_d;
    logic [15:0]           baud_q,     baud_d;
    logic                  tx_q,       tx_d;
    logic                  overflow_q, overflow_d;

    logic [7:0] mem_q [DEPTH];

    logic w_push;
    logic w_pop;
    logic w_baud_done;

    // A pop in the same cycle does not make room for a write against a full FIFO.
    assign w_push      = trigger_in && (count_q != c_depth);
    assign w_pop       = (state_q == S_IDLE) && (count_q != '0);
    assign w_baud_done = (baud_q == c_baud_last);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_d     = baud_q;
        tx_d       = tx_q;
        overflow_d = trigger_in && (count_q == c_depth);

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // tx_d always carries the level for the cycle after the edge, so the
        // line changes exactly on state/bit boundaries.
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (w_pop) begin
                    shift_d   = mem_q[rd_ptr_q];
                    baud_d    = '0;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    baud_d    = '0;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (w_baud_done) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_q     <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_q     <= baud_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign full     = (count_q == c_depth);
    assign busy     = (state_q != S_IDLE) || (count_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Randomised scoreboard bench for uart_tx_fifo with a serial-line monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DL2   = 2;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       trigger_in = 1'b0;
    logic [7:0] data_in    = 8'h00;
    logic       tx;
    logic       busy;
    logic       full;
    logic       overflow;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .DEPTH_LOG2  (DL2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trigger_in(trigger_in),
        .data_in   (data_in),
        .tx        (tx),
        .busy      (busy),
        .full      (full),
        .overflow  (overflow)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model (queue + transmitter-free time) --------
    logic [7:0] fifo_m[$];
    logic [7:0] exp_bytes[$];
    int         exp_start[$];
    int         cyc      = 0;
    int         free_at  = 0;
    int         last_pop = -1000;
    logic       exp_ovf  = 1'b0;
    logic       m_pop;
    logic       m_acc;
    logic [7:0] m_head;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=timeout_or_missing required=event cycle=%0d", name, cyc);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_m.delete();
            exp_bytes.delete();
            exp_start.delete();
            free_at = 0;
            exp_ovf = 1'b0;
        end else begin
            cyc++;
            m_pop   = (cyc >= free_at) && (fifo_m.size() > 0);
            m_acc   = trigger_in && (fifo_m.size() < DEPTH);
            exp_ovf = trigger_in && !m_acc;
            if (m_pop) begin
                m_head   = fifo_m.pop_front();
                exp_start.push_back(cyc);
                free_at  = cyc + FRAME + 1;
                last_pop = cyc;
            end
            if (m_acc) begin
                fifo_m.push_back(data_in);
                exp_bytes.push_back(data_in);
            end
        end
    end

    // ---------------- per-cycle status checks -------------------------------
    always @(negedge clk) begin
        check("full", full, (fifo_m.size() == DEPTH));
        check("busy", busy, (fifo_m.size() > 0) || (cyc < free_at - 1));
        check("overflow", overflow, exp_ovf);
    end

    // ---------------- serial-line monitor -----------------------------------
    logic       rx_active = 1'b0;
    int         rx_n      = 0;
    logic       rx_bits[FRAME];
    logic [7:0] rx_byte;
    logic       rx_ok;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active = 1'b0;
        end else begin
            if (!rx_active && tx === 1'b0) begin
                rx_active = 1'b1;
                rx_n      = 0;
                if (exp_start.size() == 0) fail_now("unexpected_start");
                else check("start_cycle", cyc, exp_start.pop_front());
            end
            if (rx_active) begin
                rx_bits[rx_n] = tx;
                rx_n++;
                if (rx_n == FRAME) begin
                    rx_active = 1'b0;
                    rx_ok     = 1'b1;
                    for (int s = 0; s < CPB; s++)
                        if (rx_bits[s] !== 1'b0) rx_ok = 1'b0;
                    for (int b = 0; b < 8; b++) begin
                        rx_byte[b] = rx_bits[CPB * (b + 1)];
                        for (int k = 0; k < CPB; k++)
                            if (rx_bits[CPB * (b + 1) + k] !== rx_byte[b]) rx_ok = 1'b0;
                    end
                    for (int s = 9 * CPB; s < FRAME; s++)
                        if (rx_bits[s] !== 1'b1) rx_ok = 1'b0;
                    check("frame_shape", rx_ok, 1'b1);
                    if (exp_bytes.size() == 0) fail_now("unexpected_byte");
                    else check("tx_byte", rx_byte, exp_bytes.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic write_byte(input logic [7:0] b);
        trigger_in = 1'b1;
        data_in    = b;
        @(negedge clk);
        trigger_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((fifo_m.size() != 0 || cyc < free_at - 1 || rx_active) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) fail_now("idle_timeout");
        repeat (3) @(negedge clk);
        check("idle_tx", tx, 1'b1);
        check("idle_left", exp_bytes.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // single byte
        write_byte(8'hEE);
        wait_idle();

        // back-to-back
        write_byte(8'h55);
        write_byte(8'hAA);
        wait_idle();

        // overflow burst 01..06
        for (int i = 1; i <= 6; i++) write_byte(8'(i));
        check("burst_full", full, 1'b1);
        wait_idle();

        // write at full on the same edge the FSM pops
        for (int i = 0; i < 5; i++) write_byte(8'(8'h11 + i));
        begin
            int n = 0;
            while (cyc != free_at - 1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) fail_now("pop_edge_timeout");
        end
        write_byte(8'h77);
        check("popfull_ovf", overflow, 1'b1);
        check("popfull_full", full, 1'b0);
        wait_idle();

        // pointer wrap, spaced so the FIFO never fills
        for (int i = 0; i < 10; i++) begin
            write_byte(8'(8'hA0 + i));
            repeat (44) @(negedge clk);
        end
        wait_idle();

        // reset during data bit 3, then restart with first-edge write
        write_byte(8'hC3);
        begin
            int n = 0;
            while (cyc != last_pop + 4 * CPB + 1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) fail_now("bit3_timeout");
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_full", full, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        trigger_in = 1'b1;
        data_in    = 8'h3C;
        @(negedge clk);
        trigger_in = 1'b0;
        check("first_write_busy", busy, 1'b1);
        wait_idle();

        // randomised traffic with occasional bursts
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                int len = $urandom_range(3, 7);
                for (int k = 0; k < len; k++) write_byte(8'($urandom));
            end else begin
                trigger_in = ($urandom_range(0, 9) == 0);
                data_in    = 8'($urandom);
                @(negedge clk);
            end
        end
        trigger_in = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=running required=finished cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, gives clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter DEPTH_LOG2, default 4, gives FIFO depth DEPTH = 2**DEPTH_LOG2 bytes; legal range 1..8.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 trigger_in  input  1  write strobe, one cycle per byte; sourced from edge_detector trigger_out.
REQ-006 data_in  input  8  byte to enqueue, sampled when trigger_in=1; sourced from edge_detector data_out.
REQ-007 tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-008 busy  output  1  high while FIFO non-empty or a frame is in progress.
REQ-009 full  output  1  high when FIFO holds DEPTH bytes.
REQ-010 overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-011 FIFO: circular buffer, DEPTH entries, write/read pointers DEPTH_LOG2 bits wrapping modulo DEPTH, count register DEPTH_LOG2+1 bits.
REQ-012 Write accepted on a rising edge where trigger_in=1 and count<DEPTH (count before the edge); byte stored at wr_ptr, wr_ptr+1.
REQ-013 Write while count==DEPTH is dropped, contents and pointers unchanged, overflow=1 the following cycle only; a same-cycle pop does not rescue the write.
REQ-014 Simultaneous accepted write and pop: both performed, count unchanged.
REQ-015 full = (count==DEPTH), combinational from registered count.
REQ-016 FSM states: IDLE, START, DATA, STOP; registered bit counter (3 bits) and baud counter (16 bits).
REQ-017 IDLE: tx=1; if count!=0 on a clock edge, pop head into shift register, clear baud counter, enter START.
REQ-018 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit counter=0.
REQ-019 DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; after bit 7 enter STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-021 Frame length exactly 10*CLKS_PER_BIT cycles from tx falling to end of STOP.
REQ-022 Back-to-back: IDLE lasts exactly one cycle between frames when FIFO non-empty (stop bit = CLKS_PER_BIT+1 cycles high).
REQ-023 Latency: byte written at edge N into empty FIFO with FSM in IDLE -> popped at edge N+1 -> tx low from edge N+1.
REQ-024 tx is a direct register output, glitch-free.
REQ-025 busy = (state!=IDLE) or (count!=0), registered-derived.
REQ-026 trigger_in held high for multiple cycles writes once per cycle (block has no edge detection of its own).

Reset
REQ-027 rst_n=0 asynchronously forces: state=IDLE, tx=1, pointers=0, count=0, shift register=0, counters=0, overflow=0; busy=0, full=0.
REQ-028 Reset mid-frame aborts the frame immediately (tx=1) and discards all FIFO contents; RAM contents need not be cleared.
REQ-029 First write accepted on the first rising edge after rst_n deasserts.

Verification (CLKS_PER_BIT=4, DEPTH_LOG2=2)
REQ-030 Single byte: pulse trigger_in with data_in=8'hEE -> tx low at next edge+1, bits 0,1,1,1,0,1,1,1 each 4 cycles, stop high, busy low after 40 cycles.
REQ-031 Back-to-back: write 8'h55, 8'hAA on consecutive cycles -> two frames, second start bit exactly 5 cycles after first stop bit begins, bytes in order.
REQ-032 Overflow: 6 consecutive writes 8'h01..8'h06 -> first popped immediately, 8'h02..8'h05 fill FIFO, full=1, 8'h06 dropped with one overflow pulse; transmitted sequence 01,02,03,04,05.
REQ-033 Pointer wrap: 10 bytes written spaced to never fill -> all 10 transmitted in order, overflow never asserted.
REQ-034 Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx=1 same cycle, busy=0, full=0; after release a new 8'h3C transmits correctly.
REQ-035 Simultaneous pop and write at full: FIFO full while IDLE pops -> write dropped, overflow pulses, count becomes DEPTH-1.
